// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and constants for the SPI master arbiter: FSM states, byte-count
// width, default timing parameters and a byte-lane extraction helper.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIN  = 3'd4,
    ST_GAP  = 3'd5
  } arb_state_e;

  localparam int BCNT_W          = 2;
  localparam int GAP_CYC_DEF     = 2;
  localparam int TIMEOUT_CYC_DEF = 255;

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [BCNT_W-1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester and byte-engine signals of the SPI master arbiter.
// The err signal exists only when SPI_ARB_TIMEOUT_EN is defined.
interface spi_master_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] req_len;
  logic [32*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [31:0]        rdata;
`ifdef SPI_ARB_TIMEOUT_EN
  logic               err;
`endif
  logic               eng_start;
  logic [7:0]         eng_wbyte;
  logic               eng_done;
  logic [7:0]         eng_rbyte;
  logic [N_REQ-1:0]   ss_sel;

  modport master (
`ifdef SPI_ARB_TIMEOUT_EN
    output err,
`endif
    input  req, req_len, req_wdata, eng_done, eng_rbyte,
    output gnt, done, rdata, eng_start, eng_wbyte, ss_sel
  );

  modport slave (
`ifdef SPI_ARB_TIMEOUT_EN
    input  err,
`endif
    output req, req_len, req_wdata, eng_done, eng_rbyte,
    input  gnt, done, rdata, eng_start, eng_wbyte, ss_sel
  );

endinterface

// File: rtl/spi_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos_s;
  logic             hit_s;

  // Walk requesters starting at ptr; the first hit claims the grant
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s         = IDX_W'((int'(ptr) + k) % N);
      hit_s         = !valid && req[pos_s];
      onehot[pos_s] = hit_s;
      idx           = hit_s ? pos_s : idx;
      valid         = valid | hit_s;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine among N_REQ requesters.
// Optional engine watchdog and err output enabled by SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                  clk,
  input logic                  reset,
  spi_master_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  arb_state_e         state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, win_idx_r, pick_idx_s;
  logic [N_REQ-1:0]   pick_oh_s, win_oh_r, gnt_r, done_r, ss_sel_r;
  logic               pick_vld_s, last_byte_s, gap_done_s, tmo_hit_s;
  logic [BCNT_W-1:0]  len_r, bidx_r;
  logic [31:0]        wdata_r, shadow_r, rdata_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               eng_start_r;
  logic [7:0]         eng_wbyte_r;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_r),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .valid  (pick_vld_s)
  );

  assign last_byte_s = (bidx_r == len_r);
  assign gap_done_s  = (gap_cnt_r == GAP_W'(GAP_CYC - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (|bus.req) state_s = ST_ARB;  else state_s = ST_IDLE;
      ST_ARB:  if (pick_vld_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: state_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.eng_done) begin
          if (last_byte_s) state_s = ST_FIN; else state_s = ST_LOAD;
        end else if (tmo_hit_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FIN:  state_s = ST_GAP;
      ST_GAP:  if (gap_done_s) state_s = ST_IDLE; else state_s = ST_GAP;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; each action lands on the edge leaving its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r       <= '0;
      win_idx_r   <= '0;
      win_oh_r    <= '0;
      len_r       <= '0;
      bidx_r      <= '0;
      wdata_r     <= 32'h0;
      shadow_r    <= 32'h0;
      rdata_r     <= 32'h0;
      gnt_r       <= '0;
      done_r      <= '0;
      ss_sel_r    <= '1;
      eng_start_r <= 1'b0;
      eng_wbyte_r <= 8'h00;
    end else begin
      eng_start_r <= 1'b0;
      done_r      <= '0;
      case (state_r)
        ST_ARB: begin
          if (pick_vld_s) begin
            win_idx_r <= pick_idx_s;
            win_oh_r  <= pick_oh_s;
            gnt_r     <= pick_oh_s;
            len_r     <= bus.req_len[2*pick_idx_s +: BCNT_W];
            wdata_r   <= bus.req_wdata[32*pick_idx_s +: 32];
            shadow_r  <= 32'h0;
            bidx_r    <= '0;
          end
        end
        ST_LOAD: begin
          ss_sel_r    <= ~win_oh_r;
          eng_wbyte_r <= get_byte(wdata_r, bidx_r);
          eng_start_r <= 1'b1;
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            shadow_r[8*bidx_r +: 8] <= bus.eng_rbyte;
            bidx_r                  <= bidx_r + BCNT_W'(1);
          end
        end
        ST_FIN: begin
          gnt_r    <= '0;
          ss_sel_r <= '1;
          done_r   <= win_oh_r;
          rdata_r  <= shadow_r;
          ptr_r    <= (win_idx_r == IDX_W'(N_REQ - 1)) ? '0 : win_idx_r + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Inter-transaction gap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  gap_cnt_r <= '0;
    else if (state_r == ST_GAP) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
    else                        gap_cnt_r <= '0;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tmo_flag_r, err_r;

  assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Engine watchdog; a completed byte restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r  <= '0;
      tmo_flag_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_WAIT && !bus.eng_done) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      else                                     tmo_cnt_r <= '0;
      if (state_r == ST_ARB)                                          tmo_flag_r <= 1'b0;
      else if (state_r == ST_WAIT && !bus.eng_done && tmo_hit_s)      tmo_flag_r <= 1'b1;
      err_r <= (state_r == ST_FIN) && tmo_flag_r;
    end
  end

  assign bus.err = err_r;
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.rdata     = rdata_r;
  assign bus.eng_start = eng_start_r;
  assign bus.eng_wbyte = eng_wbyte_r;
  assign bus.ss_sel    = ss_sel_r;

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares one byte-wide SPI engine between `N_REQ` requesters with round-robin arbitration. Each requester submits a 1–4 byte transaction with a 32-bit write word. The block sequences the bytes through the engine and drives the requester's chip-select for the whole transaction. It returns the assembled read word with a one-cycle done pulse. It sits between the Avalon-side register blocks and the SPI byte engine.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8); also the number of chip-selects.
- `GAP_CYC`, 2, minimum idle cycles with all chip-selects high between transactions (≥1).
- `TIMEOUT_CYC`, 255, engine watchdog limit in cycles (used only with `SPI_ARB_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: transaction request, level, one bit per requester.
- `req_len` in `2*N_REQ`: byte count minus 1 per requester (0 → 1 byte … 3 → 4 bytes).
- `req_wdata` in `32*N_REQ`: write word per requester; byte 0 = bits [7:0], sent first.
- `gnt` out `N_REQ`: one-hot grant, high for the whole transaction.
- `done` out `N_REQ`: one-cycle completion pulse to the granted requester.
- `rdata` out 32: assembled read word; valid in the `done` cycle and held until the next `done`.
- `err` out 1: watchdog error flag, pulses with `done`; present only with `SPI_ARB_TIMEOUT_EN`.
- `eng_start` out 1: one-cycle pulse that starts one engine byte.
- `eng_wbyte` out 8: byte to transmit; stable from `eng_start` until `eng_done`.
- `eng_done` in 1: one-cycle pulse when the engine finishes a byte; `eng_rbyte` is valid in that cycle.
- `eng_rbyte` in 8: received byte.
- `ss_sel` out `N_REQ`: active-low chip-select, one per requester.

## Operation
- Reset values: `gnt`=0, `done`=0, `rdata`=0, `err`=0, `eng_start`=0, `eng_wbyte`=0, `ss_sel`=all 1s.
- Round-robin pointer resets to 0. It is set to (granted index + 1) mod `N_REQ` after each completion.
- Arbitration picks the first set `req` bit at or above the pointer, wrapping around.
- FSM states and transitions:
  - IDLE: any `req` → ARB.
  - ARB: latch winner index, `req_len` and `req_wdata`; assert `gnt`; clear `rdata` shadow → LOAD.
  - LOAD: drive `ss_sel` low for the winner; `eng_wbyte` = byte[idx]; pulse `eng_start` → WAIT.
  - WAIT: on `eng_done`, store `eng_rbyte` into shadow bits [8·idx+7 : 8·idx]. If idx == len → FIN; otherwise idx+1 → LOAD.
  - FIN: drop `gnt`; raise `ss_sel`; pulse `done` for the winner; update `rdata` from the shadow → GAP.
  - GAP: count `GAP_CYC` cycles → IDLE.
- Bytes not transferred read back as 0 in `rdata`.
- `ss_sel` stays low continuously across all bytes of one transaction.
- Requester obligations: hold `req`, `req_len` and `req_wdata` stable until `done`. Inputs are latched in ARB, so later changes are ignored.
- Dropping `req` mid-transaction does not abort it; the transaction completes and `done` still pulses.
- A requester whose `req` is still high after `done` competes again only after GAP. A different pending requester wins if it is next in round-robin order.
- If `eng_done` arrives outside WAIT, it is ignored.
- If `reset` asserts mid-transaction, all outputs go to their reset values immediately and the FSM returns to IDLE.

## Timing
- From `req` rising at edge t: `gnt` at t+1, `ss_sel` low and `eng_start` at t+2.
- Per byte: 1 LOAD cycle plus engine latency.
- From the last `eng_done` at edge u: `done` and `rdata` at u+1, `ss_sel` high at u+1.
- Next `gnt` no earlier than u+2+`GAP_CYC`.
- Minimum idle time with all chip-selects high between transactions is `GAP_CYC`+1 cycles.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A WAIT-state counter runs. If it reaches `TIMEOUT_CYC` without `eng_done`, the FSM goes to FIN with remaining bytes read as 0 and `err`=1 in the `done` cycle.
  - The `err` port exists.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - No counter, no `err` port.

## Structure
- Shared package `spi_arb_pkg`:
  - FSM state enum (IDLE, ARB, LOAD, WAIT, FIN, GAP).
  - Byte-count width constant.
  - Default `GAP_CYC` and `TIMEOUT_CYC`.
- One sub-module, `rr_pick`: combinational round-robin picker taking `req` and the pointer and producing a one-hot winner plus its index.

## Test plan
- Reset: assert `reset` → all outputs at their reset values; `ss_sel`=4'b1111.
- Single request: `req`[2]=1, `req_len`=1, `wdata`=32'h0000_A55A, engine echoes MOSI → bytes 8'h5A then 8'hA5 sent; `ss_sel`=4'b1011 throughout; `rdata`=32'h0000_A55A; `done`[2] pulses once.
- Contention: `req`=4'b1111 held → grants in order 0,1,2,3,0; each grant separated by ≥`GAP_CYC`+1 cycles with `ss_sel` all high.
- Mid-transaction drop: `req`[1] deasserted after byte 0 of a 4-byte transfer → all 4 bytes still sent; `done`[1] pulses.
- Reset mid-transfer: `reset` asserted during WAIT of byte 2 → `ss_sel`=all 1s and `gnt`=0 in the same cycle; after release, the next `req` gets a grant 1 cycle later.
- Timeout (`SPI_ARB_TIMEOUT_EN`): engine never pulses `eng_done` → after 255 cycles, `done` and `err` pulse, `rdata`=0, `ss_sel` released.
